uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
Two-requester round-robin arbiter and sequencer that shares one UART transmitter. Requesters offer bytes through a valid/ready handshake. The block issues one tx_start pulse per byte and holds the grant until the transmitter reports tx_end. It sits between byte sources (e.g. CPU bus bridge, debug/console engine) and the UART transmitter's tx_start/tx_data/tx_busy/tx_end interface. A lock input lets one requester keep the transmitter for a multi-byte packet.

Parameters:
TIMEOUT_CYC, 16'd50000, max cycles in WAIT before abort (used only with UART_ARB_TIMEOUT_EN)
TIMEOUT_W, 16, width of timeout counter

Ports:
clk  in  1  system clock
reset_  in  1  asynchronous reset, active-low
req0_valid  in  1  requester 0 has a byte
req0_data  in  8  requester 0 byte
req0_lock  in  1  requester 0 holds ownership after this byte
req0_ready  out  1  1-cycle pulse: req0 byte accepted
req1_valid  in  1  requester 1 has a byte
req1_data  in  8  requester 1 byte
req1_lock  in  1  requester 1 holds ownership after this byte
req1_ready  out  1  1-cycle pulse: req1 byte accepted
tx_busy  in  1  transmitter busy
tx_end  in  1  transmitter finished frame (1-cycle pulse)
tx_start  out  1  1-cycle start pulse to transmitter
tx_data  out  8  byte to transmit
grant  out  2  one-hot current owner (00 = none)
arb_busy  out  1  high in ISSUE and WAIT
err  out  1  1-cycle timeout pulse

Behaviour:
- Reset (reset_ low, async): state=IDLE; tx_start=0; tx_data=8'h00; req0_ready=req1_ready=0; grant=2'b00; arb_busy=0; err=0; last=1 (req0 wins first contest); owned=0; timer=0.
- All outputs registered.
- States: IDLE, ISSUE, WAIT.
- IDLE, selection:
  - Acts only when tx_busy=0.
  - If owned=1, only the owner is eligible.
  - Otherwise: if exactly one valid is high, that requester wins. If both are high, the requester other than last wins.
  - On selection: next cycle state=ISSUE, tx_start=1, tx_data=winner data, winner ready=1, grant=winner, last=winner, owned=winner lock.
  - Latency: valid sampled in cycle N gives tx_start/ready in cycle N+1.
- IDLE, owner release: if owned=1 and the owner has valid=0 and lock=0, then owned=0 and grant=00 next cycle.
- IDLE, no selection: grant=00 unless owned=1.
- IDLE, other signals: tx_data=8'h00.
- ISSUE: lasts exactly 1 cycle. tx_start and ready fall next cycle. Then state=WAIT.
- WAIT:
  - tx_data and grant held stable.
  - Requester valids are ignored; ready stays 0.
  - On tx_end=1: state=IDLE next cycle. grant=00 if owned=0, otherwise kept.
  - Earliest next tx_start is 2 cycles after tx_end.
- tx_end while in IDLE or ISSUE: ignored.
- tx_busy=1 while in IDLE: no issue; arbitration waits.
- A requester's data and lock must be stable while its valid is high; they are sampled only on the selection cycle. A valid that drops before acceptance is simply not selected.
- Back-to-back lock=1 bytes from the owner: the other requester is never granted, even when valid, until the owner releases.
- A byte accepted with lock=0 clears owned. The next contest is then normal round-robin.
- Reset asserted mid-transfer: immediate return to reset values. The in-flight frame is the transmitter's concern; no ready is reissued.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - timer clears on entry to WAIT and increments every WAIT cycle.
  - If timer reaches TIMEOUT_CYC-1 with no tx_end, then next cycle: state=IDLE, err=1 for 1 cycle, owned=0, grant=00, tx_data=8'h00.
  - tx_end in the same cycle as expiry wins: normal completion, no err.
- Not defined:
  - No timer logic; WAIT waits indefinitely for tx_end.
  - err tied to 0.

Test Plan:
- Single byte: req0_valid=1, data=8'hA5, lock=0 at cycle 10 -> tx_start and req0_ready high at cycle 11 only, tx_data=8'hA5, grant=01. tx_end at cycle 100 -> grant=00, tx_data=00 at 101.
- Contention: req0 and req1 both valid continuously (0x11, 0x22) with tx_end 20 cycles after each start -> tx_data sequence 11, 22, 11, 22, ...; first grant goes to req0 after reset.
- Lock packet: req1 sends 3 bytes lock=1,1,0 while req0_valid=1 throughout -> all three req1 bytes transmitted before any req0 byte; req0 granted on the next contest.
- Owner release: req0 byte lock=1, then req0_valid=0, lock=0 in IDLE -> grant=00 next cycle; a pending req1 is issued the following cycle.
- tx_busy gating and stray tx_end: hold tx_busy=1 with req0 valid -> no tx_start. tx_end pulsed in IDLE -> no state change. Drop tx_busy -> tx_start 1 cycle later.
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): issue a byte, never pulse tx_end -> err=1 exactly 16 cycles after entering WAIT, grant=00. tx_end on the expiry cycle -> no err.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one UART transmitter between two byte requesters.
// Optional WAIT-state abort timer is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arb #(
    parameter int                   TIMEOUT_W   = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_lock,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_lock,
    output logic       req1_ready,
    input  logic       tx_busy,
    input  logic       tx_end,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [1:0] grant,
    output logic       arb_busy,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t     state, state_next;
    logic       last, owned;
    logic       last_next, owned_next;
    logic       start_next, ready0_next, ready1_next, busy_next, err_next;
    logic [7:0] data_next;
    logic [1:0] grant_next;
    logic       pick, pick_id, owner_release, expire;

    // While a lock is held, last names the owner, so only that requester competes.
    always_comb begin
        pick    = 1'b0;
        pick_id = 1'b0;
        if (!tx_busy) begin
            if (owned) begin
                pick    = last ? req1_valid : req0_valid;
                pick_id = last;
            end else if (req0_valid && req1_valid) begin
                pick    = 1'b1;
                pick_id = ~last;
            end else if (req0_valid || req1_valid) begin
                pick    = 1'b1;
                pick_id = req1_valid;
            end
        end
    end

    assign owner_release = owned && !(last ? req1_valid : req0_valid)
                                 && !(last ? req1_lock  : req0_lock);

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYC - 1'b1;

    logic [TIMEOUT_W-1:0] timer;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            timer <= '0;
        else if (state == ISSUE)
            timer <= '0;
        else if (state == WAIT)
            timer <= timer + 1'b1;
    end

    // A tx_end arriving on the expiry cycle takes precedence over the abort.
    assign expire = (state == WAIT) && !tx_end && (timer == TIMEOUT_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYC, TIMEOUT_W};
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= IDLE;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            grant      <= 2'b00;
            arb_busy   <= 1'b0;
            err        <= 1'b0;
            last       <= 1'b1;
            owned      <= 1'b0;
        end else begin
            state      <= state_next;
            tx_start   <= start_next;
            tx_data    <= data_next;
            req0_ready <= ready0_next;
            req1_ready <= ready1_next;
            grant      <= grant_next;
            arb_busy   <= busy_next;
            err        <= err_next;
            last       <= last_next;
            owned      <= owned_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pick) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (tx_end || expire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Computes the registered output values for the coming cycle.
    always_comb begin
        start_next  = 1'b0;
        ready0_next = 1'b0;
        ready1_next = 1'b0;
        err_next    = 1'b0;
        data_next   = tx_data;
        grant_next  = grant;
        last_next   = last;
        owned_next  = owned;
        busy_next   = (state_next != IDLE);
        unique case (state)
            IDLE: begin
                data_next = 8'h00;
                if (pick) begin
                    start_next  = 1'b1;
                    data_next   = pick_id ? req1_data : req0_data;
                    ready0_next = ~pick_id;
                    ready1_next = pick_id;
                    grant_next  = pick_id ? 2'b10 : 2'b01;
                    last_next   = pick_id;
                    owned_next  = pick_id ? req1_lock : req0_lock;
                end else if (owner_release) begin
                    owned_next = 1'b0;
                    grant_next = 2'b00;
                end else if (!owned) begin
                    grant_next = 2'b00;
                end
            end
            ISSUE: begin
            end
            WAIT: begin
                if (tx_end) begin
                    data_next = 8'h00;
                    if (!owned) grant_next = 2'b00;
                end else if (expire) begin
                    err_next   = 1'b1;
                    owned_next = 1'b0;
                    grant_next = 2'b00;
                    data_next  = 8'h00;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed, table-driven bench for uart_tx_arb; the timeout sequence runs only when
// UART_ARB_TIMEOUT_EN is defined (TIMEOUT_CYC overridden to 16).
module tb_uart_tx_arb;

    logic       clk = 1'b0;
    logic       reset_;
    logic       req0_valid, req0_lock, req0_ready;
    logic       req1_valid, req1_lock, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic       tx_busy, tx_end, tx_start, arb_busy, err;
    logic [7:0] tx_data;
    logic [1:0] grant;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string      name;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       busy;
        logic       tend;
        logic       exp_start;
        logic [7:0] exp_data;
        logic       exp_r0;
        logic       exp_r1;
        logic [1:0] exp_grant;
        logic       exp_abusy;
    } vec_t;

    vec_t vecs[$];

    uart_tx_arb #(.TIMEOUT_W(16), .TIMEOUT_CYC(16'd16)) dut (
        .clk        (clk),
        .reset_     (reset_),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_lock  (req0_lock),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_lock  (req1_lock),
        .req1_ready (req1_ready),
        .tx_busy    (tx_busy),
        .tx_end     (tx_end),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .grant      (grant),
        .arb_busy   (arb_busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string n,
                                input logic v0, input logic [7:0] d0, input logic l0,
                                input logic v1, input logic [7:0] d1, input logic l1,
                                input logic busy, input logic tend,
                                input logic st, input logic [7:0] dat, input logic r0,
                                input logic r1, input logic [1:0] g, input logic ab);
        vec_t v;
        v.name = n; v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1;
        v.busy = busy; v.tend = tend; v.exp_start = st; v.exp_data = dat;
        v.exp_r0 = r0; v.exp_r1 = r1; v.exp_grant = g; v.exp_abusy = ab;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        req0_valid = v.v0; req0_data = v.d0; req0_lock = v.l0;
        req1_valid = v.v1; req1_data = v.d1; req1_lock = v.l1;
        tx_busy = v.busy; tx_end = v.tend;
        @(posedge clk);
        #1;
        check_output({v.name, ".tx_start"}, 8'(tx_start), 8'(v.exp_start));
        check_output({v.name, ".tx_data"}, tx_data, v.exp_data);
        check_output({v.name, ".req0_ready"}, 8'(req0_ready), 8'(v.exp_r0));
        check_output({v.name, ".req1_ready"}, 8'(req1_ready), 8'(v.exp_r1));
        check_output({v.name, ".grant"}, 8'(grant), 8'(v.exp_grant));
        check_output({v.name, ".arb_busy"}, 8'(arb_busy), 8'(v.exp_abusy));
        check_output({v.name, ".err"}, 8'(err), 8'h00);
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req0_data = 8'h00; req0_lock = 0;
        req1_valid = 0; req1_data = 8'h00; req1_lock = 0;
        tx_busy = 0; tx_end = 0;
    endtask

    initial begin
        //            name          v0 d0    l0 v1 d1    l1 bz te st dat   r0 r1 g      ab
        vecs.push_back(mk("idle",      0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));
        vecs.push_back(mk("single0",   1, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 1, 0, 2'b01, 1));
        vecs.push_back(mk("issue_end", 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 0, 0, 2'b01, 1));
        vecs.push_back(mk("wait_ign",  0, 8'h00, 0, 1, 8'h22, 0, 0, 0, 0, 8'hA5, 0, 0, 2'b01, 1));
        vecs.push_back(mk("end_a5",    0, 8'h00, 0, 1, 8'h22, 0, 0, 1, 0, 8'h00, 0, 0, 2'b00, 0));
        vecs.push_back(mk("single1",   0, 8'h00, 0, 1, 8'h22, 0, 0, 0, 1, 8'h22, 0, 1, 2'b10, 1));
        vecs.push_back(mk("wait1",     0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h22, 0, 0, 2'b10, 1));
        vecs.push_back(mk("end1",      0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 2'b00, 0));
        vecs.push_back(mk("rr_a",      1, 8'h11, 0, 1, 8'h22, 0, 0, 0, 1, 8'h11, 1, 0, 2'b01, 1));
        vecs.push_back(mk("rr_a_w",    1, 8'h11, 0, 1, 8'h22, 0, 0, 0, 0, 8'h11, 0, 0, 2'b01, 1));
        vecs.push_back(mk("rr_a_end",  1, 8'h11, 0, 1, 8'h22, 0, 0, 1, 0, 8'h00, 0, 0, 2'b00, 0));
        vecs.push_back(mk("rr_b",      1, 8'h11, 0, 1, 8'h22, 0, 0, 0, 1, 8'h22, 0, 1, 2'b10, 1));
        vecs.push_back(mk("rr_b_w",    1, 8'h11, 0, 1, 8'h22, 0, 0, 0, 0, 8'h22, 0, 0, 2'b10, 1));
        vecs.push_back(mk("rr_b_end",  1, 8'h11, 0, 1, 8'h22, 0, 0, 1, 0, 8'h00, 0, 0, 2'b00, 0));
        vecs.push_back(mk("pre_lock",  1, 8'h33, 0, 0, 8'h00, 0, 0, 0, 1, 8'h33, 1, 0, 2'b01, 1));
        vecs.push_back(mk("pre_w",     0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h33, 0, 0, 2'b01, 1));
        vecs.push_back(mk("pre_end",   0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 2'b00, 0));
        vecs.push_back(mk("lock_b1",   1, 8'h11, 0, 1, 8'h44, 1, 0, 0, 1, 8'h44, 0, 1, 2'b10, 1));
        vecs.push_back(mk("lock_w1",   1, 8'h11, 0, 1, 8'h44, 1, 0, 0, 0, 8'h44, 0, 0, 2'b10, 1));
        vecs.push_back(mk("lock_e1",   1, 8'h11, 0, 1, 8'h44, 1, 0, 1, 0, 8'h00, 0, 0, 2'b10, 0));
        vecs.push_back(mk("lock_b2",   1, 8'h11, 0, 1, 8'h55, 1, 0, 0, 1, 8'h55, 0, 1, 2'b10, 1));
        vecs.push_back(mk("lock_w2",   1, 8'h11, 0, 1, 8'h55, 1, 0, 0, 0, 8'h55, 0, 0, 2'b10, 1));
        vecs.push_back(mk("lock_e2",   1, 8'h11, 0, 1, 8'h55, 1, 0, 1, 0, 8'h00, 0, 0, 2'b10, 0));
        vecs.push_back(mk("lock_b3",   1, 8'h11, 0, 1, 8'h66, 0, 0, 0, 1, 8'h66, 0, 1, 2'b10, 1));
        vecs.push_back(mk("lock_w3",   1, 8'h11, 0, 1, 8'h66, 0, 0, 0, 0, 8'h66, 0, 0, 2'b10, 1));
        vecs.push_back(mk("lock_e3",   1, 8'h11, 0, 1, 8'h66, 0, 0, 1, 0, 8'h00, 0, 0, 2'b00, 0));
        vecs.push_back(mk("post_lock", 1, 8'h11, 0, 1, 8'h77, 0, 0, 0, 1, 8'h11, 1, 0, 2'b01, 1));
        vecs.push_back(mk("post_w",    0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h11, 0, 0, 2'b01, 1));
        vecs.push_back(mk("post_end",  0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 2'b00, 0));
        vecs.push_back(mk("own0",      1, 8'h88, 1, 0, 8'h00, 0, 0, 0, 1, 8'h88, 1, 0, 2'b01, 1));
        vecs.push_back(mk("own0_w",    0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h88, 0, 0, 2'b01, 1));
        vecs.push_back(mk("own0_end",  0, 8'h00, 0, 1, 8'h99, 0, 0, 1, 0, 8'h00, 0, 0, 2'b01, 0));
        vecs.push_back(mk("release",   0, 8'h00, 0, 1, 8'h99, 0, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));
        vecs.push_back(mk("rel_pick1", 0, 8'h00, 0, 1, 8'h99, 0, 0, 0, 1, 8'h99, 0, 1, 2'b10, 1));
        vecs.push_back(mk("rel_w",     0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h99, 0, 0, 2'b10, 1));
        vecs.push_back(mk("rel_end",   0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 2'b00, 0));
        vecs.push_back(mk("busy_hold", 1, 8'hAB, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 2'b00, 0));
        vecs.push_back(mk("stray_end", 1, 8'hAB, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 2'b00, 0));
        vecs.push_back(mk("busy_drop", 1, 8'hAB, 0, 0, 8'h00, 0, 0, 0, 1, 8'hAB, 1, 0, 2'b01, 1));
        vecs.push_back(mk("end_issue", 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 8'hAB, 0, 0, 2'b01, 1));
        vecs.push_back(mk("ab_wait",   0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'hAB, 0, 0, 2'b01, 1));
        vecs.push_back(mk("ab_end",    0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 2'b00, 0));

        clear_inputs();
        reset_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst.tx_start", 8'(tx_start), 8'h00);
        check_output("rst.tx_data", tx_data, 8'h00);
        check_output("rst.grant", 8'(grant), 8'h00);
        check_output("rst.ready", 8'({req1_ready, req0_ready}), 8'h00);
        check_output("rst.arb_busy", 8'(arb_busy), 8'h00);
        check_output("rst.err", 8'(err), 8'h00);
        reset_ = 1'b1;

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Reset in the middle of a transfer returns outputs to idle without a clock edge.
        apply_stimulus(mk("mid_sel",   0, 8'h00, 0, 1, 8'h5A, 0, 0, 0, 1, 8'h5A, 0, 1, 2'b10, 1));
        apply_stimulus(mk("mid_wait",  0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h5A, 0, 0, 2'b10, 1));
        reset_ = 1'b0;
        #2;
        check_output("mid_rst.grant", 8'(grant), 8'h00);
        check_output("mid_rst.tx_data", tx_data, 8'h00);
        check_output("mid_rst.arb_busy", 8'(arb_busy), 8'h00);
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(mk("after_rst", 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));
        apply_stimulus(mk("rst_last",  1, 8'h01, 0, 1, 8'h02, 0, 0, 0, 1, 8'h01, 1, 0, 2'b01, 1));
        apply_stimulus(mk("rst_w",     0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h01, 0, 0, 2'b01, 1));
        apply_stimulus(mk("rst_end",   0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 2'b00, 0));

`ifdef UART_ARB_TIMEOUT_EN
        for (int pass = 0; pass < 2; pass++) begin
            clear_inputs();
            req0_valid = 1; req0_data = 8'hC3;
            @(posedge clk);
            #1;
            check_output("to.start", 8'(tx_start), 8'h01);
            req0_valid = 0;
            for (int k = 1; k <= 16; k++) begin
                @(posedge clk);
                #1;
                check_output("to.early_err", 8'(err), 8'h00);
            end
            tx_end = (pass == 1);
            @(posedge clk);
            #1;
            tx_end = 0;
            check_output("to.expiry_err", 8'(err), (pass == 0) ? 8'h01 : 8'h00);
            check_output("to.grant", 8'(grant), 8'h00);
            check_output("to.tx_data", tx_data, 8'h00);
            check_output("to.arb_busy", 8'(arb_busy), 8'h00);
            @(posedge clk);
            #1;
            check_output("to.err_pulse", 8'(err), 8'h00);
        end
`endif

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
